// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external combinational 4-bit ALU among NUM_REQ
// requesters using round-robin arbitration. Requests use a valid/ready
// handshake. Operands are registered towards the ALU. The ALU result and
// carry are captured and returned with the owner's index over a valid/ready
// response channel.
//
// Optional feature, enabled by defining ALU_RR_ARBITER_STATS_EN:
//   adds stats_clr (input) and op_count[7:0] (output).
//   op_count is a saturating count of response handshakes, and stats_clr
//   clears it synchronously.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [1:0]           alu_sel,
  input  logic [3:0]           alu_result,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_result,
  output logic                 rsp_carry,
  output logic [ID_W-1:0]      rsp_id
`ifdef ALU_RR_ARBITER_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [7:0]           op_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic [1:0]      alu_sel_q, alu_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [3:0]      rsp_result_q, rsp_result_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  // Arbitration results and the winner's operands.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand_idx;
  logic [3:0]      win_a;
  logic [3:0]      win_b;
  logic [1:0]      win_op;

  // Round-robin search: the first valid requester at or after last+1, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Operand mux: select the winning requester's slice of the packed buses.
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        win_a  = req_a[4*i +: 4];
        win_b  = req_b[4*i +: 4];
        win_op = req_op[2*i +: 2];
      end
    end
  end

  // Accept pulse: one-hot on the winner, only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && (state_q == ST_IDLE) && grant_found &&
                     (grant_idx == ID_W'(i));
    end
  end

  // Next-state and datapath updates for IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          alu_a_d   = win_a;
          alu_b_d   = win_b;
          alu_sel_d = win_op;
          rsp_id_d  = grant_idx;
          last_d    = grant_idx;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable for a full cycle, so its outputs are settled.
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= ID_W'(NUM_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_id     = rsp_id_q;

`ifdef ALU_RR_ARBITER_STATS_EN
  logic [7:0] op_count_q, op_count_d;

  // Handshake counter: a clear wins over an increment, and the count saturates at 8'hFF.
  always_comb begin
    op_count_d = op_count_q;
    if (stats_clr) begin
      op_count_d = '0;
    end else if ((state_q == ST_RESP) && rsp_valid_q && rsp_ready &&
                 (op_count_q != 8'hFF)) begin
      op_count_d = op_count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
